hex_entry: RTL and testbench

- Operator-input front end: builds a 32-bit hex word one nibble at a time from board buttons and a 4-bit switch group.
- Exposes the in-progress word in nibble-indexed form (nibble 0 = dig[3:0] ... nibble 7 = dig[31:28]) so the 7-segment scan path can display it directly.
- On Enter, commits the word to the CPU I/O side with a one-cycle valid pulse.
- Contains raw-button synchronisation, debounce, edge detection and the edit buffer.

---
 rtl/hex_entry.sv | 151 +++++++++++++++
 tb/tb_hex_entry.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hex_entry.sv
// Operator hex-entry front end: synchronises and debounces four buttons, then
// edits a 32-bit nibble buffer and commits it to the CPU side on Enter.
module hex_entry #(
  parameter int unsigned DEB_CYCLES = 20'd500000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_val,
  input  logic        key_press,
  input  logic        key_bksp,
  input  logic        key_clr,
  input  logic        key_enter,
  output logic [31:0] dig,
  output logic [3:0]  digit_count,
  output logic [7:0]  blank_mask,
  output logic        full,
  output logic [31:0] data_out,
  output logic        data_valid
);

  localparam int unsigned BTN_PRESS = 0;
  localparam int unsigned BTN_BKSP  = 1;
  localparam int unsigned BTN_CLR   = 2;
  localparam int unsigned BTN_ENTER = 3;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [3:0]       w_btn_raw;
  logic [3:0]       r_btn_p0;
  logic [3:0]       r_btn_p1;
  logic [3:0]       r_val_p0;
  logic [3:0]       r_val_p1;
  logic [CNT_W-1:0] r_deb_cnt [4];
  logic [3:0]       r_stable;
  logic [3:0]       r_pulse;

  logic [31:0]      r_dig;
  logic [3:0]       r_count;
  logic [7:0]       r_blank;
  logic             r_full;
  logic [31:0]      r_data_out;
  logic             r_data_valid;

  logic [31:0]      w_dig_nx;
  logic [3:0]       w_count_nx;
  logic             w_commit;

  // Unentered nibbles are the ones at or above the current count.
  function automatic logic [7:0] blank_of(input logic [3:0] count);
    logic [7:0] mask;
    mask = 8'hFF << count;
    return mask;
  endfunction

  assign w_btn_raw = {key_enter, key_clr, key_bksp, key_press};

  // Stage p0/p1: two-flop synchronisers for buttons and switch value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_p0 <= '0;
      r_btn_p1 <= '0;
      r_val_p0 <= '0;
      r_val_p1 <= '0;
    end else begin
      r_btn_p0 <= w_btn_raw;
      r_btn_p1 <= r_btn_p0;
      r_val_p0 <= key_val;
      r_val_p1 <= r_val_p0;
    end
  end

  // Debounce: the action pulse is registered on the same edge the stable
  // level rises, so a press costs no extra cycle for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_deb_cnt[i] <= '0;
      end
      r_stable <= '0;
      r_pulse  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_btn_p1[i] == r_stable[i]) begin
          r_deb_cnt[i] <= '0;
          r_pulse[i]   <= 1'b0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb_cnt[i] <= '0;
          r_stable[i]  <= r_btn_p1[i];
          r_pulse[i]   <= r_btn_p1[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
          r_pulse[i]   <= 1'b0;
        end
      end
    end
  end

  // Edit actions, one per cycle in priority clr > enter > bksp > digit
  always_comb begin
    w_dig_nx   = r_dig;
    w_count_nx = r_count;
    w_commit   = 1'b0;
    if (r_pulse[BTN_CLR]) begin
      w_dig_nx   = '0;
      w_count_nx = '0;
    end else if (r_pulse[BTN_ENTER]) begin
      w_commit   = 1'b1;
      w_dig_nx   = '0;
      w_count_nx = '0;
    end else if (r_pulse[BTN_BKSP]) begin
      if (r_count != 4'd0) begin
        w_dig_nx   = {4'h0, r_dig[31:4]};
        w_count_nx = r_count - 4'd1;
      end
    end else if (r_pulse[BTN_PRESS]) begin
      if (r_count != 4'd8) begin
        w_dig_nx   = {r_dig[27:0], r_val_p1};
        w_count_nx = r_count + 4'd1;
      end
    end
  end

  // Stage p2: edit buffer, derived display outputs and commit port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig        <= '0;
      r_count      <= '0;
      r_blank      <= 8'hFF;
      r_full       <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_dig        <= w_dig_nx;
      r_count      <= w_count_nx;
      r_blank      <= blank_of(w_count_nx);
      r_full       <= (w_count_nx == 4'd8);
      r_data_valid <= w_commit;
      if (w_commit) begin
        r_data_out <= r_dig;
      end
    end
  end

  assign dig         = r_dig;
  assign digit_count = r_count;
  assign blank_mask  = r_blank;
  assign full        = r_full;
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;

endmodule

// File: tb/tb_hex_entry.sv
// Directed bench for hex_entry with a short debounce window (4 cycles).
module tb_hex_entry;

  logic        clk;
  logic        rst;
  logic [3:0]  key_val;
  logic [3:0]  btn;
  logic [31:0] dig;
  logic [3:0]  digit_count;
  logic [7:0]  blank_mask;
  logic        full;
  logic [31:0] data_out;
  logic        data_valid;

  int n_tests;
  int n_fail;
  int n_valid;

  hex_entry #(.DEB_CYCLES(4), .CNT_W(20)) dut (
    .clk(clk),
    .rst(rst),
    .key_val(key_val),
    .key_press(btn[0]),
    .key_bksp(btn[1]),
    .key_clr(btn[2]),
    .key_enter(btn[3]),
    .dig(dig),
    .digit_count(digit_count),
    .blank_mask(blank_mask),
    .full(full),
    .data_out(data_out),
    .data_valid(data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && data_valid) n_valid++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold button(s) for 8 cycles, release, and let the release debounce.
  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    btn = mask;
    repeat (8) @(negedge clk);
    btn = 4'h0;
    repeat (8) @(negedge clk);
  endtask

  task automatic press_digit(input logic [3:0] v);
    key_val = v;
    press(4'b0001);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_valid = 0;
    rst     = 1'b1;
    key_val = 4'h5;
    btn     = 4'hF;

    // reset with every button held
    repeat (3) @(negedge clk);
    chk("rst_dig", dig, 32'h0);
    chk("rst_count", {28'h0, digit_count}, 32'd0);
    chk("rst_blank", {24'h0, blank_mask}, 32'hFF);
    chk("rst_full", {31'h0, full}, 32'd0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_valid", {31'h0, data_valid}, 32'd0);

    // key_press still held after release of reset: one digit after 7 edges
    rst = 1'b0;
    btn = 4'b0001;
    repeat (6) @(posedge clk);
    #1 chk("post_rst_edge6", {28'h0, digit_count}, 32'd0);
    @(posedge clk);
    #1 chk("post_rst_edge7_dig", dig, 32'h5);
    chk("post_rst_blank", {24'h0, blank_mask}, 32'hFE);
    @(negedge clk);
    btn = 4'h0;
    repeat (8) @(negedge clk);
    chk("post_rst_once", {28'h0, digit_count}, 32'd1);
    press(4'b0100);
    chk("clr_dig", dig, 32'h0);
    chk("clr_count", {28'h0, digit_count}, 32'd0);

    // entry of 1,2,3 with exact latency
    for (int v = 1; v <= 3; v++) begin
      key_val = 4'(v);
      @(negedge clk);
      btn = 4'b0001;
      repeat (6) @(posedge clk);
      #1 chk("entry_edge6", {28'h0, digit_count}, 32'(v - 1));
      @(posedge clk);
      #1 chk("entry_edge7", {28'h0, digit_count}, 32'(v));
      @(negedge clk);
      btn = 4'h0;
      repeat (8) @(negedge clk);
    end
    chk("entry_dig", dig, 32'h00000123);
    chk("entry_blank", {24'h0, blank_mask}, 32'hF8);
    chk("entry_full", {31'h0, full}, 32'd0);

    // backspace down to empty and once more
    press(4'b0010);
    chk("bksp1", dig, 32'h12);
    press(4'b0010);
    chk("bksp2", dig, 32'h1);
    press(4'b0010);
    chk("bksp3", dig, 32'h0);
    chk("bksp3_count", {28'h0, digit_count}, 32'd0);
    press(4'b0010);
    chk("bksp_empty", dig, 32'h0);
    chk("bksp_empty_count", {28'h0, digit_count}, 32'd0);
    chk("bksp_empty_blank", {24'h0, blank_mask}, 32'hFF);

    // overflow: 9th digit ignored
    for (int v = 1; v <= 9; v++) press_digit(4'(v));
    chk("ovf_dig", dig, 32'h12345678);
    chk("ovf_count", {28'h0, digit_count}, 32'd8);
    chk("ovf_full", {31'h0, full}, 32'd1);
    chk("ovf_blank", {24'h0, blank_mask}, 32'h00);

    // commit
    press(4'b0100);
    press_digit(4'hA);
    press_digit(4'hB);
    press_digit(4'hC);
    press_digit(4'hD);
    chk("pre_commit", dig, 32'hABCD);
    @(negedge clk);
    btn = 4'b1000;
    repeat (7) @(posedge clk);
    #1 chk("commit_valid", {31'h0, data_valid}, 32'd1);
    chk("commit_data", data_out, 32'h0000ABCD);
    chk("commit_dig", dig, 32'h0);
    chk("commit_count", {28'h0, digit_count}, 32'd0);
    @(posedge clk);
    #1 chk("commit_valid_drop", {31'h0, data_valid}, 32'd0);
    @(negedge clk);
    btn = 4'h0;
    repeat (8) @(negedge clk);
    chk("commit_pulses", 32'(n_valid), 32'd1);

    // clear and enter together: clear wins
    press_digit(4'h7);
    press(4'b1100);
    chk("prio_dig", dig, 32'h0);
    chk("prio_pulses", 32'(n_valid), 32'd1);
    chk("prio_data", data_out, 32'h0000ABCD);

    // 3-cycle glitch ignored
    key_val = 4'h9;
    @(negedge clk);
    btn = 4'b0001;
    repeat (3) @(negedge clk);
    btn = 4'h0;
    repeat (10) @(negedge clk);
    chk("glitch_count", {28'h0, digit_count}, 32'd0);

    // 100-cycle hold gives exactly one digit
    key_val = 4'h6;
    btn = 4'b0001;
    repeat (100) @(negedge clk);
    btn = 4'h0;
    repeat (10) @(negedge clk);
    chk("hold_dig", dig, 32'h6);
    chk("hold_count", {28'h0, digit_count}, 32'd1);

    // reset mid-edit
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_dig", dig, 32'h0);
    chk("midrst_blank", {24'h0, blank_mask}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
